// File: rtl/lgn_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lgn_frame_sequencer
// Description : Streams one bit-packed image into the LGN core, waits out the
//               core pipeline and captures the class index / score.
// Revision    : 1.0 - initial release
// ============================================================================
module lgn_frame_sequencer #(
  parameter int IMG_BYTES = 98,
  parameter int LATENCY   = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] core_ui_in,
  output logic       core_load,
  input  logic [3:0] core_index,
  input  logic [7:0] core_value,
  output logic       busy,
  output logic       res_valid,
  output logic [3:0] res_index,
  output logic [7:0] res_value,
  output logic [7:0] frames_done
);

  localparam int             c_LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]   c_BYTE_LAST = CNT_W'(IMG_BYTES - 1);
  localparam logic [c_LAT_W-1:0] c_LAT_LAST  = c_LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [c_LAT_W-1:0] r_lat_cnt;
  logic [7:0]         r_core_ui_in;
  logic               r_core_load;
  logic               r_busy;
  logic               r_res_valid;
  logic [3:0]         r_res_index;
  logic [7:0]         r_res_value;
  logic [7:0]         r_frames_done;
  logic               w_handshake;
  logic               w_accept;
  logic               w_capture;

  assign s_ready     = (r_state == ST_LOAD);
  assign w_handshake = s_ready && s_valid;
  // A byte taken in the same cycle as abort is discarded with the frame.
  assign w_accept    = w_handshake && !abort;
  assign w_capture   = (r_state == ST_DONE) && !abort;

  always_comb begin
    w_state_nx = r_state;
    if (abort) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) w_state_nx = ST_LOAD;
        ST_LOAD: if (w_handshake && (r_byte_cnt == c_BYTE_LAST)) w_state_nx = ST_WAIT;
        ST_WAIT: if (r_lat_cnt == c_LAT_LAST) w_state_nx = ST_DONE;
        ST_DONE: w_state_nx = ST_IDLE;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_byte_cnt    <= '0;
      r_lat_cnt     <= '0;
      r_core_ui_in  <= '0;
      r_core_load   <= 1'b0;
      r_busy        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_index   <= '0;
      r_res_value   <= '0;
      r_frames_done <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_busy      <= (w_state_nx == ST_LOAD) || (w_state_nx == ST_WAIT);
      r_core_load <= w_accept;
      r_res_valid <= w_capture;

      if (w_accept) r_core_ui_in <= s_data;

      if (abort || (r_state != ST_LOAD) || (w_accept && (r_byte_cnt == c_BYTE_LAST)))
        r_byte_cnt <= '0;
      else if (w_accept)
        r_byte_cnt <= r_byte_cnt + 1'b1;

      // Counts from the final load-pulse cycle, which is the first WAIT cycle.
      if (!abort && (r_state == ST_WAIT))
        r_lat_cnt <= r_lat_cnt + 1'b1;
      else
        r_lat_cnt <= '0;

      if (w_capture) begin
        r_res_index   <= core_index;
        r_res_value   <= core_value;
        r_frames_done <= r_frames_done + 8'd1;
      end
    end
  end

  assign core_ui_in  = r_core_ui_in;
  assign core_load   = r_core_load;
  assign busy        = r_busy;
  assign res_valid   = r_res_valid;
  assign res_index   = r_res_index;
  assign res_value   = r_res_value;
  assign frames_done = r_frames_done;

endmodule
`default_nettype wire

// File: doc/lgn_frame_sequencer.md
Name: lgn_frame_sequencer

Overview:
Sequences one inference on the LGN MNIST core. On a start request it accepts one bit-packed 28x28 image (IMG_BYTES bytes) from an upstream valid/ready byte stream (UART or flash reader) and presents it to the core one byte per load strobe. It then waits a fixed pipeline latency, captures the core's class index and score, and holds them for the seven-segment and LED display logic. It sits between the board top level and the core's ui_in/uio_in/uo_out/uio_out pins.

Parameters:
IMG_BYTES, 98, bytes per image (784 pixels, 1 bit each, LSB = first pixel)
LATENCY, 16, clk cycles from last load strobe to valid core outputs; must be >= 1
CNT_W, 8, width of byte counter; must satisfy 2^CNT_W > IMG_BYTES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to run an inference; level held high is treated as one request per IDLE visit
abort  in  1  return to IDLE from any state, discarding partial image
s_data  in  8  image byte from upstream
s_valid  in  1  s_data valid
s_ready  out  1  sequencer accepts s_data this cycle
core_ui_in  out  8  byte driven onto core ui_in
core_load  out  1  load strobe to core (uio_in[7])
core_index  in  4  core class index (uio_out[3:0])
core_value  in  8  core score (uo_out)
busy  out  1  high in LOAD, WAIT
res_valid  out  1  one-cycle pulse when result captured
res_index  out  4  last captured class index
res_value  out  8  last captured score
frames_done  out  8  completed inference count

Behaviour:
- Async reset: state=IDLE; all outputs 0; byte and latency counters 0.
- States: IDLE, LOAD, WAIT, DONE. All outputs registered except s_ready (= state==LOAD).
- IDLE: s_ready=0, busy=0. start=1 -> LOAD, byte_cnt<=0.
- LOAD: busy=1, s_ready=1. On s_valid&s_ready: core_ui_in<=s_data, core_load<=1 next cycle only (single-cycle pulse per byte), byte_cnt++. Without a handshake, core_load=0 and core_ui_in holds its last value. On the handshake with byte_cnt==IMG_BYTES-1 -> WAIT, lat_cnt<=0. Back-to-back bytes give back-to-back load pulses.
- WAIT: busy=1, s_ready=0. lat_cnt increments every cycle from the cycle after the final core_load pulse. When lat_cnt==LATENCY-1 -> DONE.
- DONE (one cycle): res_index<=core_index, res_value<=core_value, res_valid=1 in the following cycle, frames_done++ (wraps 255->0), -> IDLE. busy=0 in DONE.
- res_index/res_value hold until the next DONE or reset. abort does not clear them.
- start while busy: ignored, not queued. start high in DONE: ignored; sampled again in IDLE.
- abort (highest priority, any state): next state IDLE, core_load<=0, counters cleared, no res_valid, frames_done unchanged. abort and start in the same IDLE cycle: stay IDLE.
- core_index values 10..15 are captured unmodified; the display decoder handles them.
- Mid-operation reset: immediate return to reset values; no partial result is exposed.
- Result latency with a continuous stream: first s_ready at T+1 after start at T; res_valid at T+1+IMG_BYTES+LATENCY+1.

Test Plan:
- Reset then start, stream 98 bytes 0x00..0x61 with s_valid always 1 -> 98 consecutive core_load pulses, core_ui_in tracks bytes in order, s_ready drops after byte 97.
- Same frame with core_index=7, core_value=0xA5 stable; LATENCY=16 -> res_valid pulses exactly once 16+1 cycles after last load, res_index=7, res_value=0xA5, frames_done=1.
- Upstream stalls (s_valid toggled randomly 50%) -> load pulses only on handshakes, exactly 98 total, same result timing relative to last load.
- abort asserted after 40 bytes -> IDLE next cycle, s_ready=0, no res_valid, res_index keeps previous 7, next start needs a full 98 bytes.
- start pulsed during LOAD and WAIT -> no effect; 256 completed frames -> frames_done wraps to 0.
- rst asserted during WAIT -> all outputs 0 asynchronously, state IDLE, res_valid never pulses.
